// File: rtl/x_load_ctrl.sv
// Sequencer for the matrix unit's X operand buffer: fetches packed X words from ROM
// column by column, then drives the per-column shift/MAC window.
module x_load_ctrl #(
    parameter int ADDR_W       = 4,
    parameter int BASE_ADDR    = 0,
    parameter int N_COLS       = 8,
    parameter int FIRST_WORDS  = 2,
    parameter int OTHER_WORDS  = 1,
    parameter int SHIFT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clr,
    input  logic              rom_valid,
    input  logic              mac_ready,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              load_en,
    output logic [2:0]        col_counter,
    output logic              x_shift,
    output logic              mac_en,
    output logic              busy,
    output logic              done
);

    localparam int MAX_WORDS = (FIRST_WORDS > OTHER_WORDS) ? FIRST_WORDS : OTHER_WORDS;
    localparam int WORD_W    = $clog2(MAX_WORDS + 1);
    localparam int BEAT_W    = (SHIFT_CYCLES > 1) ? $clog2(SHIFT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] words;
    logic [BEAT_W-1:0] beats;
    logic [WORD_W-1:0] word_target;
    logic              last_word;
    logic              last_beat;
    logic              last_col;

    // Column 0 carries extra words, so its load phase is longer.
    always_comb begin
        word_target = (col_counter == 3'd0) ? WORD_W'(FIRST_WORDS) : WORD_W'(OTHER_WORDS);
        last_word   = (words == word_target - WORD_W'(1));
        last_beat   = (beats == BEAT_W'(SHIFT_CYCLES - 1));
        last_col    = (col_counter == 3'(N_COLS - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            rom_addr    <= ADDR_W'(BASE_ADDR);
            col_counter <= 3'd0;
            words       <= '0;
            beats       <= '0;
        end else if (clr) begin
            // Abort keeps the address and column so the last position stays visible.
            state <= IDLE;
            words <= '0;
            beats <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= LOAD;
                        rom_addr    <= ADDR_W'(BASE_ADDR);
                        col_counter <= 3'd0;
                    end
                end
                LOAD: begin
                    if (rom_valid) begin
                        rom_addr <= rom_addr + ADDR_W'(1);
                        if (last_word) begin
                            words <= '0;
                            state <= SHIFT;
                        end else begin
                            words <= words + WORD_W'(1);
                        end
                    end
                end
                SHIFT: begin
                    if (mac_ready) begin
                        if (last_beat) begin
                            beats <= '0;
                            if (last_col) begin
                                state <= DONE;
                            end else begin
                                col_counter <= col_counter + 3'd1;
                                state       <= LOAD;
                            end
                        end else begin
                            beats <= beats + BEAT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes are gated by clr so nothing is accepted or shifted in the abort cycle.
    always_comb begin
        load_en = (state == LOAD) && !clr;
        x_shift = (state == SHIFT) && mac_ready && !clr;
        mac_en  = x_shift;
        done    = (state == DONE) && !clr;
        busy    = (state != IDLE);
    end

endmodule

// File: tb/tb_x_load_ctrl.sv
// Scoreboard bench for x_load_ctrl: directed passes push expected word/beat/done events,
// monitors pop and compare them as the DUTs present them.
module tb_x_load_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start2;
    logic       clr;
    logic       rom_valid;
    logic       mac_ready;

    logic [3:0] rom_addr;
    logic       load_en;
    logic [2:0] col_counter;
    logic       x_shift;
    logic       mac_en;
    logic       busy;
    logic       done;

    logic [3:0] rom_addr2;
    logic       load_en2;
    logic [2:0] col_counter2;
    logic       x_shift2;
    logic       mac_en2;
    logic       busy2;
    logic       done2;

    typedef struct {
        int addr;
        int col;
    } word_t;

    word_t q_word[$];
    word_t q2_word[$];
    int    q_beat[$];
    int    q_done[$];
    int    q2_done[$];

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    beats2 = 0;
    int    t0;
    word_t mon_w;
    word_t mon2_w;
    int    mon_col;
    int    mon_done;
    int    mon2_done;

    x_load_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .clr(clr),
        .rom_valid(rom_valid), .mac_ready(mac_ready),
        .rom_addr(rom_addr), .load_en(load_en), .col_counter(col_counter),
        .x_shift(x_shift), .mac_en(mac_en), .busy(busy), .done(done)
    );

    x_load_ctrl #(.BASE_ADDR(14)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .clr(clr),
        .rom_valid(rom_valid), .mac_ready(mac_ready),
        .rom_addr(rom_addr2), .load_en(load_en2), .col_counter(col_counter2),
        .x_shift(x_shift2), .mac_en(mac_en2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cyc %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic c, input logic rv, input logic mr);
        start     = s;
        clr       = c;
        rom_valid = rv;
        mac_ready = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    // Expected events of one uninterrupted pass on the BASE_ADDR=0 instance.
    task automatic push_full_pass(input int done_at);
        int off = 0;
        for (int c = 0; c < 8; c++) begin
            for (int w = 0; w < ((c == 0) ? 2 : 1); w++) begin
                q_word.push_back('{off % 16, c});
                off++;
            end
            for (int b = 0; b < 4; b++) q_beat.push_back(c);
        end
        q_done.push_back(done_at);
    endtask

    always @(negedge clk) begin
        if (load_en && rom_valid) begin
            checkOutput("word pending", int'(q_word.size() > 0), 1);
            if (q_word.size() > 0) begin
                mon_w = q_word.pop_front();
                checkOutput("word rom_addr", int'(rom_addr), mon_w.addr);
                checkOutput("word col_counter", int'(col_counter), mon_w.col);
            end
        end
        if (x_shift || mac_en) begin
            checkOutput("beat pending", int'(q_beat.size() > 0), 1);
            if (q_beat.size() > 0) begin
                mon_col = q_beat.pop_front();
                checkOutput("beat col_counter", int'(col_counter), mon_col);
            end
            checkOutput("beat x_shift", int'(x_shift), 1);
            checkOutput("beat mac_en", int'(mac_en), 1);
            checkOutput("load_en during shift", int'(load_en), 0);
        end
        if (done) begin
            checkOutput("done pending", int'(q_done.size() > 0), 1);
            if (q_done.size() > 0) begin
                mon_done = q_done.pop_front();
                checkOutput("done cycle", cyc, mon_done);
            end
        end
    end

    always @(negedge clk) begin
        if (load_en2 && rom_valid) begin
            checkOutput("wrap word pending", int'(q2_word.size() > 0), 1);
            if (q2_word.size() > 0) begin
                mon2_w = q2_word.pop_front();
                checkOutput("wrap rom_addr", int'(rom_addr2), mon2_w.addr);
                checkOutput("wrap col_counter", int'(col_counter2), mon2_w.col);
            end
        end
        if (x_shift2 || mac_en2) begin
            beats2++;
            checkOutput("wrap mac_en", int'(mac_en2), 1);
        end
        if (done2) begin
            checkOutput("wrap done pending", int'(q2_done.size() > 0), 1);
            if (q2_done.size() > 0) begin
                mon2_done = q2_done.pop_front();
                checkOutput("wrap done cycle", cyc, mon2_done);
            end
        end
    end

    initial begin
        int wrap_addr[9];
        wrap_addr = '{14, 15, 0, 1, 2, 3, 4, 5, 6};

        rst    = 1'b0;
        start2 = 1'b0;
        applyStimulus(0, 0, 0, 0);
        tick();
        tick();
        checkOutput("reset rom_addr", int'(rom_addr), 0);
        checkOutput("reset col_counter", int'(col_counter), 0);
        checkOutput("reset load_en", int'(load_en), 0);
        checkOutput("reset x_shift", int'(x_shift), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset rom_addr wrap", int'(rom_addr2), 14);
        rst = 1'b1;
        tick();

        $display("[TB] start with clr in IDLE");
        applyStimulus(1, 1, 1, 1);
        tick();
        applyStimulus(0, 0, 1, 1);
        checkOutput("clr beats start busy", int'(busy), 0);

        $display("[TB] full pass");
        applyStimulus(1, 0, 1, 1);
        t0 = cyc;
        push_full_pass(t0 + 42);
        tick();
        applyStimulus(0, 0, 1, 1);
        checkOutput("pass busy", int'(busy), 1);
        wait_until(t0 + 43);
        checkOutput("pass end busy", int'(busy), 0);
        checkOutput("pass end rom_addr", int'(rom_addr), 9);
        checkOutput("pass end col_counter", int'(col_counter), 7);

        $display("[TB] ROM stall");
        applyStimulus(1, 0, 1, 1);
        t0 = cyc;
        push_full_pass(t0 + 45);
        tick();
        applyStimulus(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall load_en", int'(load_en), 1);
            checkOutput("stall rom_addr", int'(rom_addr), 0);
            tick();
        end
        applyStimulus(0, 0, 1, 1);
        wait_until(t0 + 46);
        checkOutput("stall end busy", int'(busy), 0);

        $display("[TB] MAC stall");
        applyStimulus(1, 0, 1, 1);
        t0 = cyc;
        push_full_pass(t0 + 44);
        tick();
        applyStimulus(0, 0, 1, 1);
        wait_until(t0 + 19);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 1, 0);
            #1;
            checkOutput("mac stall x_shift", int'(x_shift), 0);
            checkOutput("mac stall col_counter", int'(col_counter), 3);
            tick();
        end
        applyStimulus(0, 0, 1, 1);
        wait_until(t0 + 45);
        checkOutput("mac stall end busy", int'(busy), 0);

        $display("[TB] abort then restart");
        applyStimulus(1, 0, 1, 1);
        t0 = cyc;
        q_word.push_back('{0, 0});
        q_word.push_back('{1, 0});
        for (int c = 1; c < 4; c++) q_word.push_back('{c + 1, c});
        for (int i = 0; i < 14; i++) q_beat.push_back(i / 4);
        tick();
        applyStimulus(0, 0, 1, 1);
        wait_until(t0 + 20);
        applyStimulus(0, 1, 1, 1);
        tick();
        applyStimulus(1, 0, 1, 1);
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort done", int'(done), 0);
        checkOutput("abort rom_addr held", int'(rom_addr), 5);
        checkOutput("abort col_counter held", int'(col_counter), 3);
        t0 = cyc;
        push_full_pass(t0 + 42);
        tick();
        applyStimulus(0, 0, 1, 1);
        wait_until(t0 + 43);
        checkOutput("restart end rom_addr", int'(rom_addr), 9);
        checkOutput("restart end busy", int'(busy), 0);

        $display("[TB] address wrap and ignored start");
        t0 = cyc;
        start2 = 1'b1;
        for (int i = 0; i < 9; i++) q2_word.push_back('{wrap_addr[i], (i < 2) ? 0 : i - 1});
        q2_done.push_back(t0 + 42);
        tick();
        start2 = 1'b0;
        wait_until(t0 + 9);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        wait_until(t0 + 43);
        checkOutput("wrap end busy", int'(busy2), 0);
        checkOutput("wrap end rom_addr", int'(rom_addr2), 7);
        checkOutput("wrap end col_counter", int'(col_counter2), 7);
        checkOutput("wrap beat count", beats2, 32);

        $display("[TB] reset mid-pass");
        applyStimulus(1, 0, 1, 1);
        t0 = cyc;
        q_word.push_back('{0, 0});
        q_word.push_back('{1, 0});
        q_word.push_back('{2, 1});
        for (int i = 0; i < 7; i++) q_beat.push_back(i / 4);
        tick();
        applyStimulus(0, 0, 1, 1);
        wait_until(t0 + 10);
        rst = 1'b0;
        tick();
        checkOutput("mid reset busy", int'(busy), 0);
        checkOutput("mid reset rom_addr", int'(rom_addr), 0);
        checkOutput("mid reset col_counter", int'(col_counter), 0);
        checkOutput("mid reset load_en", int'(load_en), 0);
        checkOutput("mid reset x_shift", int'(x_shift), 0);
        rst = 1'b1;
        tick();
        tick();

        checkOutput("words left", q_word.size(), 0);
        checkOutput("beats left", q_beat.size(), 0);
        checkOutput("done left", q_done.size(), 0);
        checkOutput("wrap words left", q2_word.size(), 0);
        checkOutput("wrap done left", q2_done.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
